mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 13 +
 rtl/wait_timer.sv | 28 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared arbiter state encoding and default abort limit
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - saturating RAM wait counter, flags expiry at LIMIT
module wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 2);

  logic [W-1:0] count;

  assign expired = (count == W'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction fetch and data access
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ready,
  output logic [31:0]       i_data,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  output logic              err
);

  state_t state, state_nx;
  logic   lock;
  logic   resp_d;
  logic   err_q;
  logic   d_wr;
  logic   expired;
  logic   in_acc;
  logic   acc_done;

  wire unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                            d_addr[31:ADDR_W+2], d_addr[1:0]};

  assign in_acc   = (state == IACC) || (state == DACC);
  assign acc_done = in_acc && (ram_ack || expired);

  wait_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_acc),
    .enable  (in_acc && !ram_ack),
    .expired (expired)
  );

  assign i_ready = (state == RESP) && !resp_d;
  assign d_ready = (state == RESP) && resp_d;
  assign err     = (state == RESP) && err_q;

  always_comb begin
    state_nx  = state;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        // lock hands the next grant to the fetch side after any data response
        if ((d_ren || d_wen) && !lock) begin
          state_nx = DACC;
        end else if (i_req) begin
          state_nx = IACC;
        end
      end
      IACC: begin
        ram_ren  = 1'b1;
        ram_addr = i_addr[ADDR_W+1:2];
        if (ram_ack || expired) begin
          state_nx = RESP;
        end
      end
      DACC: begin
        ram_ren   = d_ren && !d_wen;
        ram_wen   = d_wen;
        ram_addr  = d_addr[ADDR_W+1:2];
        ram_wdata = d_wdata;
        if (ram_ack || expired) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lock    <= 1'b0;
      resp_d  <= 1'b0;
      err_q   <= 1'b0;
      d_wr    <= 1'b0;
      i_data  <= '0;
      d_rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == DACC) begin
        d_wr <= d_wen;
      end
      if (acc_done) begin
        err_q  <= !ram_ack;
        resp_d <= (state == DACC);
        lock   <= (state == DACC);
        if (state == IACC) begin
          i_data <= ram_ack ? ram_rdata : 32'h0;
        end else if (!d_wr || !ram_ack) begin
          // completed stores leave load data alone; an aborted access reads as zero
          d_rdata <= ram_ack ? ram_rdata : 32'h0;
        end
      end
    end
  end

endmodule
